// File: rtl/forward_hazard_unit_pkg.sv
// Shared CPU pipeline types: forward select codes and the hazard tracker slot record.
package forward_hazard_unit_pkg;

    // Widest register index the slot record can hold; narrower indices are zero-extended.
    localparam int MAX_REG_BITS = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                    valid;
        logic [MAX_REG_BITS-1:0] rd;
        logic                    regwrite;
        logic                    isload;
    } hazard_slot_t;

    localparam hazard_slot_t EMPTY_SLOT = '0;

    // A slot only produces a forwardable value if it really writes a non-zero register.
    function automatic logic is_live(input hazard_slot_t slot);
        return slot.valid && slot.regwrite && (slot.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_compare.sv
// Picks the forward source for one ID operand: nearest live producer wins, x0 never forwards.
module fwd_compare
    import forward_hazard_unit_pkg::*;
#(
    parameter int NrOfRegBits = 5
) (
    input  logic [NrOfRegBits-1:0] src,
    input  logic                   use_src,
    input  hazard_slot_t           ex_slot,
    input  hazard_slot_t           mem_slot,
    output fwd_sel_t               code
);

    logic [MAX_REG_BITS-1:0] src_ext;
    logic                    ex_hit;
    logic                    mem_hit;

    assign src_ext = MAX_REG_BITS'(src);
    assign ex_hit  = use_src && is_live(ex_slot)  && (ex_slot.rd  == src_ext);
    assign mem_hit = use_src && is_live(mem_slot) && (mem_slot.rd == src_ext);

    always_comb begin
        code = FWD_RF;
        if (ex_hit) begin
            code = FWD_EXMEM;
        end else if (mem_hit) begin
            code = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks the EX and MEM producers of a 5-stage pipeline and derives operand forwarding
// selects plus the one-cycle load-use stall for the instruction sitting in ID.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int NrOfRegBits  = 5,
    parameter int StallCntBits = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Tick,
    input  logic                    Flush,
    input  logic                    IdValid,
    input  logic [NrOfRegBits-1:0]  IdRs1,
    input  logic [NrOfRegBits-1:0]  IdRs2,
    input  logic                    IdUseRs1,
    input  logic                    IdUseRs2,
    input  logic [NrOfRegBits-1:0]  IdRd,
    input  logic                    IdRegWrite,
    input  logic                    IdIsLoad,
    output logic [1:0]              Rs1Forward,
    output logic [1:0]              Rs2Forward,
    output logic                    Stall,
    output logic [StallCntBits-1:0] StallCount
);

    hazard_slot_t            ex_slot;
    hazard_slot_t            mem_slot;
    fwd_sel_t                rs1_code;
    fwd_sel_t                rs2_code;
    logic                    stall;
    logic [StallCntBits-1:0] stall_count;

    fwd_compare #(.NrOfRegBits(NrOfRegBits)) u_rs1_cmp (
        .src      (IdRs1),
        .use_src  (IdUseRs1),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .code     (rs1_code)
    );

    fwd_compare #(.NrOfRegBits(NrOfRegBits)) u_rs2_cmp (
        .src      (IdRs2),
        .use_src  (IdUseRs2),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .code     (rs2_code)
    );

    // An EX-forward hit on a load means the data is not ready yet; Flush cancels the consumer.
    assign stall = IdValid && !Flush && ex_slot.isload &&
                   ((rs1_code == FWD_EXMEM) || (rs2_code == FWD_EXMEM));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ex_slot     <= EMPTY_SLOT;
            mem_slot    <= EMPTY_SLOT;
            stall_count <= '0;
        end else if (Tick) begin
            mem_slot <= ex_slot;
            if (stall || Flush || !IdValid) begin
                ex_slot <= EMPTY_SLOT;
            end else begin
                ex_slot.valid    <= 1'b1;
                ex_slot.rd       <= MAX_REG_BITS'(IdRd);
                ex_slot.regwrite <= IdRegWrite;
                ex_slot.isload   <= IdIsLoad;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + StallCntBits'(1);
            end
        end
    end

    assign Rs1Forward = rs1_code;
    assign Rs2Forward = rs2_code;
    assign Stall      = stall;
    assign StallCount = stall_count;

endmodule
